// File: rtl/free_list.sv
// Physical-register free list for a rename stage: a circular buffer with a
// speculative allocation head, a commit head for flush recovery, and a tail.
module free_list #(
    parameter int  NUM_PHYS = 64,
    parameter int  NUM_ARCH = 32,
    localparam int DEPTH    = NUM_PHYS - NUM_ARCH,
    localparam int MW       = $clog2(NUM_PHYS),
    localparam int IW       = $clog2(DEPTH),
    localparam int PW       = IW + 1
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          alloc_req,
    output logic [MW-1:0] alloc_map,
    output logic          alloc_valid,
    input  logic          free_flag,
    input  logic [MW-1:0] free_reg,
    input  logic          commit_flag,
    input  logic          flush,
    output logic [PW-1:0] count,
    output logic          overflow_err
);

    logic [MW-1:0] buffer [DEPTH];
    logic [PW-1:0] head_spec;
    logic [PW-1:0] head_commit;
    logic [PW-1:0] tail;

    logic          full;
    logic          do_alloc;
    logic          free_ok;
    logic          do_push;
    logic          do_commit;
    logic [PW-1:0] commit_next;

    // Pointers carry one extra wrap bit, so plain subtraction yields 0..DEPTH.
    assign count       = tail - head_spec;
    assign full        = (count == PW'(DEPTH));
    assign alloc_valid = (count != '0);
    assign alloc_map   = buffer[head_spec[IW-1:0]];

    assign do_alloc    = alloc_req & alloc_valid & ~flush;
    assign free_ok     = free_flag & (free_reg != '0);
    assign do_push     = free_ok & ~full;
    assign do_commit   = commit_flag & (head_commit != head_spec);
    assign commit_next = head_commit + PW'(do_commit);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                buffer[i] <= MW'(NUM_ARCH + i);
            end
            head_spec    <= '0;
            head_commit  <= '0;
            tail         <= PW'(DEPTH);
            overflow_err <= 1'b0;
        end else begin
            head_commit <= commit_next;
            // A flush rewinds to the commit point including this cycle's commit.
            if (flush) begin
                head_spec <= commit_next;
            end else if (do_alloc) begin
                head_spec <= head_spec + PW'(1);
            end
            if (do_push) begin
                buffer[tail[IW-1:0]] <= free_reg;
                tail                 <= tail + PW'(1);
            end
            if (free_ok & full) begin
                overflow_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list: a queue-based model of the free/in-flight
// registers is compared every cycle, plus hand-computed checkpoints.
module tb_free_list;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       alloc_req = 1'b0;
    logic [5:0] alloc_map;
    logic       alloc_valid;
    logic       free_flag = 1'b0;
    logic [5:0] free_reg = '0;
    logic       commit_flag = 1'b0;
    logic       flush = 1'b0;
    logic [5:0] count;
    logic       overflow_err;

    int total = 0;
    int bad   = 0;

    // Model: avail holds allocatable registers in order, inflight holds
    // allocated but not yet committed ones (oldest first).
    int avail[$];
    int inflight[$];
    bit m_ovf;
    bit model_ok = 1'b0;

    free_list dut (
        .CLK(CLK),
        .RESET(RESET),
        .alloc_req(alloc_req),
        .alloc_map(alloc_map),
        .alloc_valid(alloc_valid),
        .free_flag(free_flag),
        .free_reg(free_reg),
        .commit_flag(commit_flag),
        .flush(flush),
        .count(count),
        .overflow_err(overflow_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit req, input bit ff, input int fr,
                              input bit cf, input bit fl);
        int  cnt;
        bit  do_alloc;
        bit  do_free;
        if (r) begin
            avail.delete();
            inflight.delete();
            for (int i = 0; i < 32; i++) avail.push_back(32 + i);
            m_ovf = 1'b0;
            return;
        end
        cnt      = avail.size();
        do_alloc = req && cnt != 0 && !fl;
        do_free  = ff && fr != 0 && cnt < 32;
        if (ff && fr != 0 && cnt == 32) m_ovf = 1'b1;
        if (cf && inflight.size() != 0) void'(inflight.pop_front());
        if (do_alloc) inflight.push_back(avail.pop_front());
        if (fl) begin
            avail = {inflight, avail};
            inflight.delete();
        end
        if (do_free) avail.push_back(fr);
    endtask

    // Drive one cycle of inputs, advance the model, return just after the
    // following falling edge so DUT outputs reflect this cycle's effect.
    task automatic step(input bit r, input bit req, input bit ff, input int fr,
                        input bit cf, input bit fl);
        RESET       = r;
        alloc_req   = req;
        free_flag   = ff;
        free_reg    = 6'(fr);
        commit_flag = cf;
        flush       = fl;
        model_step(r, req, ff, fr, cf, fl);
        model_ok = 1'b1;
        @(negedge CLK);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic expect_state(input string name, input int map, input int valid,
                                input int cnt, input int ovf);
        if (valid != 0) chk({name, ".map"}, alloc_map, map);
        chk({name, ".valid"}, alloc_valid, valid);
        chk({name, ".count"}, count, cnt);
        chk({name, ".ovf"}, overflow_err, ovf);
    endtask

    always @(negedge CLK) begin
        if (model_ok) begin
            chk("cyc.count", count, avail.size());
            chk("cyc.valid", alloc_valid, avail.size() != 0);
            chk("cyc.ovf", overflow_err, m_ovf);
            if (avail.size() != 0) chk("cyc.map", alloc_map, avail[0]);
        end
    end

    initial begin
        int prev;
        int cur;
        @(negedge CLK);
        #1;

        // Reset state
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        expect_state("reset", 32, 1, 32, 0);

        // Drain the whole list in order
        for (int i = 0; i < 32; i++) begin
            chk("drain.map", alloc_map, 32 + i);
            step(0, 1, 0, 0, 0, 0);
        end
        expect_state("drained", 0, 0, 0, 0);

        // Free into empty list with same-cycle alloc: no bypass
        step(0, 1, 1, 5, 0, 0);
        expect_state("nobypass", 5, 1, 1, 0);
        step(0, 1, 0, 0, 0, 0);
        expect_state("nobypass.used", 0, 0, 0, 0);

        // Alloc 3, commit one, flush back to the commit head
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0);
        expect_state("alloc3", 35, 1, 29, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0, 1);
        expect_state("flush", 33, 1, 31, 0);

        // Commit, flush and free in one cycle
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 9, 1, 1);
        expect_state("cfflush", 33, 1, 32, 0);

        // Full-list free is dropped and sets overflow; free of reg 0 ignored
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 7, 0, 0);
        expect_state("ovf", 32, 1, 32, 1);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        expect_state("free0", 33, 1, 31, 1);

        // 40 allocations interleaved with frees of returned registers
        step(1, 0, 0, 0, 0, 0);
        prev = avail[0];
        step(0, 1, 0, 0, 0, 0);
        for (int i = 1; i < 40; i++) begin
            cur = avail[0];
            step(0, 1, 1, prev, 1, 0);
            prev = cur;
        end
        expect_state("wrap.mid", 40, 1, 31, 0);
        step(0, 0, 1, prev, 1, 0);
        expect_state("wrap.end", 40, 1, 32, 0);

        // Reset overrides free/flush/alloc/commit mid-operation
        step(0, 0, 1, 7, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(1, 1, 1, 9, 1, 1);
        expect_state("midreset", 32, 1, 32, 0);
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
